// File: rtl/hog_pkg.sv
// hog_pkg: shared sizing helpers for the HOG block assembler.
// Contents: cell_w() gives the packed width of one cell histogram,
// blk_cnt() gives the number of 2x2 blocks in a CELLS_X x CELLS_Y grid.
package hog_pkg;
   function automatic int cell_w(input int bin_w, input int n_bin);
      return bin_w * n_bin;
   endfunction
   function automatic int blk_cnt(input int cells_x, input int cells_y);
      return (cells_x - 1) * (cells_y - 1);
   endfunction
endpackage

// File: rtl/hog_block_assembler_if.sv
// hog_block_assembler_if: cell-in / block-out stream bundle.
// Ports: bin, i_valid, i_sof, i_ready (cell side); o_valid, o_ready, bid,
// fea_a..fea_d, o_last (block side). master = producer/consumer, slave = assembler.
interface hog_block_assembler_if #(
   parameter int CELL_W = 288,
   parameter int ID_W   = 13
);
   logic [CELL_W-1:0] bin;
   logic              i_valid;
   logic              i_sof;
   logic              i_ready;
   logic              o_valid;
   logic              o_ready;
   logic [ID_W-1:0]   bid;
   logic [CELL_W-1:0] fea_a;
   logic [CELL_W-1:0] fea_b;
   logic [CELL_W-1:0] fea_c;
   logic [CELL_W-1:0] fea_d;
   logic              o_last;
   modport master (
      output bin, i_valid, i_sof, o_ready,
      input  i_ready, o_valid, bid, fea_a, fea_b, fea_c, fea_d, o_last
   );
   modport slave (
      input  bin, i_valid, i_sof, o_ready,
      output i_ready, o_valid, bid, fea_a, fea_b, fea_c, fea_d, o_last
   );
endinterface

// File: rtl/hog_line_buf.sv
// hog_line_buf: one-row cell buffer, read-before-write on a shared address.
// Ports: clk; en (access strobe, also holds rdata when low); addr; wdata; rdata (registered).
module hog_line_buf #(
   parameter  int DEPTH = 80,
   parameter  int W     = 288,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         en,
   input  logic [AW-1:0] addr,
   input  logic [W-1:0]  wdata,
   output logic [W-1:0]  rdata
);
   logic [W-1:0] mem [DEPTH];
   always_ff @(posedge clk) begin
      if (en) begin
         rdata     <= mem[addr];
         mem[addr] <= wdata;
      end
   end
endmodule

// File: rtl/hog_block_assembler.sv
// hog_block_assembler: turns raster-order cell histograms into 2x2 blocks.
// Ports: clk; rst (sync, active-low); bus (slave side of hog_block_assembler_if):
// cells in on bin/i_valid/i_sof/i_ready, blocks out on o_valid/o_ready with
// bid, fea_a (x-1,y-1), fea_b (x,y-1), fea_c (x-1,y), fea_d (x,y) and o_last.
module hog_block_assembler
   import hog_pkg::*;
#(
   parameter int BIN_W   = 32,
   parameter int N_BIN   = 9,
   parameter int CELLS_X = 80,
   parameter int CELLS_Y = 60,
   parameter int ID_W    = 13
) (
   input logic                  clk,
   input logic                  rst,
   hog_block_assembler_if.slave bus
);
   localparam int CELL_W = cell_w(BIN_W, N_BIN);
   localparam int N_BLK  = blk_cnt(CELLS_X, CELLS_Y);
   localparam int XW     = $clog2(CELLS_X);
   localparam int YW     = $clog2(CELLS_Y);
   typedef logic [N_BIN-1:0][BIN_W-1:0] cell_t;

   logic            stall, acc, emit;
   logic [XW-1:0]   x, cx, s1_x;
   logic [YW-1:0]   y, cy, s1_y;
   logic            s1_v;
   cell_t           s1_cell, up, lt, lb;
   logic [ID_W-1:0] bid_n;

   assign stall       = bus.o_valid && !bus.o_ready;
   assign bus.i_ready = !stall;
   assign acc         = bus.i_valid && !stall;
   // sof overrides the running counters for the cell being accepted
   assign cx          = bus.i_sof ? '0 : x;
   assign cy          = bus.i_sof ? '0 : y;
   assign emit        = s1_v && s1_x != '0 && s1_y != '0;
   assign bid_n       = ID_W'((int'(s1_y) - 1) * (CELLS_X - 1) + int'(s1_x) - 1);

   // up = cell (x,y-1): the row buffer still holds the previous row at x
   hog_line_buf #(.DEPTH(CELLS_X), .W(CELL_W)) u_line_buf (
      .clk   (clk),
      .en    (acc),
      .addr  (cx),
      .wdata (bus.bin),
      .rdata (up)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         x <= '0;
         y <= '0;
      end else if (acc) begin
         x <= (int'(cx) == CELLS_X - 1) ? '0 : cx + 1'b1;
         y <= (int'(cx) != CELLS_X - 1) ? cy : (int'(cy) == CELLS_Y - 1) ? '0 : cy + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst)
         s1_v <= 1'b0;
      else if (!stall)
         s1_v <= acc;
   end

   always_ff @(posedge clk) begin
      if (acc) begin
         s1_cell <= bus.bin;
         s1_x    <= cx;
         s1_y    <= cy;
      end
   end

   // left column pair, becomes fea_a/fea_c for the next cell in the row
   always_ff @(posedge clk) begin
      if (!stall && s1_v) begin
         lt <= up;
         lb <= s1_cell;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         bus.o_valid <= 1'b0;
         bus.bid     <= '0;
         bus.fea_a   <= '0;
         bus.fea_b   <= '0;
         bus.fea_c   <= '0;
         bus.fea_d   <= '0;
         bus.o_last  <= 1'b0;
      end else if (!stall) begin
         bus.o_valid <= emit;
         bus.o_last  <= emit && bid_n == ID_W'(N_BLK - 1);
         if (emit) begin
            bus.bid   <= bid_n;
            bus.fea_a <= lt;
            bus.fea_b <= up;
            bus.fea_c <= lb;
            bus.fea_d <= s1_cell;
         end
      end
   end
endmodule

// File: tb/tb_hog_block_assembler.sv
// tb_hog_block_assembler: scoreboard bench for hog_block_assembler on a 4x3 grid.
module tb_hog_block_assembler;
   localparam int BIN_W = 8, N_BIN = 2, CX = 4, CY = 3, ID_W = 4, CW = 16;

   typedef struct {
      int            bid;
      logic [CW-1:0] a, b, c, d;
      bit            last;
      int            acc;
      bit            lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   hog_block_assembler_if #(.CELL_W(CW), .ID_W(ID_W)) bus ();
   hog_block_assembler #(
      .BIN_W(BIN_W), .N_BIN(N_BIN), .CELLS_X(CX), .CELLS_Y(CY), .ID_W(ID_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   exp_t          q[$];
   logic [CW-1:0] grid [CY][CX];
   int            mx, my;
   int            n_chk = 0, n_err = 0;
   int            cyc = 0;
   int            mode = 0;
   bit            lat_mode = 0;
   int            bp_cnt = 0;
   bit            bp_done = 0;
   bit            was_stall = 0;
   logic [69:0]   held;

   always @(posedge clk) cyc <= cyc + 1;

   // reference model: store the frame as a 2-D array, emit a block when the
   // bottom-right cell of a 2x2 window arrives
   task automatic model(input logic [CW-1:0] v, input bit sof, input int acc);
      exp_t e;
      if (sof) begin
         mx = 0;
         my = 0;
      end
      grid[my][mx] = v;
      if (mx > 0 && my > 0) begin
         e.bid  = (my - 1) * (CX - 1) + mx - 1;
         e.a    = grid[my-1][mx-1];
         e.b    = grid[my-1][mx];
         e.c    = grid[my][mx-1];
         e.d    = v;
         e.last = (mx == CX - 1 && my == CY - 1);
         e.acc  = acc;
         e.lat  = lat_mode;
         q.push_back(e);
      end
      mx++;
      if (mx == CX) begin
         mx = 0;
         my = (my + 1) % CY;
      end
   endtask

   task automatic send(input logic [CW-1:0] v, input bit sof);
      int n = 0;
      bus.bin = v;
      bus.i_valid = 1'b1;
      bus.i_sof = sof;
      @(negedge clk);
      while (!bus.i_ready) begin
         n++;
         if (n > 500) begin
            n_err++;
            $display("FAIL send_timeout: i_ready low for %0d cycles, required 1", n);
            $fatal(1, "input stalled");
         end
         @(negedge clk);
      end
      model(v, sof, cyc + 1);
      @(posedge clk);
      #1;
      bus.i_valid = 1'b0;
      bus.i_sof = 1'b0;
   endtask

   task automatic idle(input int n);
      bus.i_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic cells(input int base, input int n, input bit sof0);
      for (int i = 0; i < n; i++) begin
         logic [7:0] k;
         k = 8'(base + i);
         send({k, k}, sof0 && i == 0);
      end
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() > 0 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      idle(3);
      n_chk++;
      if (q.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d blocks still expected, required 0", q.size());
         q.delete();
      end
   endtask

   // downstream ready: always 1, random, or a single 3-cycle hold on bid 2
   initial begin
      bus.o_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (mode == 2 && !bp_done && bus.o_valid && bus.bid == 4'd2) begin
            bp_cnt = 3;
            bp_done = 1;
         end
         bus.o_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : (bp_cnt == 0);
         if (bp_cnt > 0) bp_cnt--;
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         n_chk++;
         if (bus.i_ready !== !(bus.o_valid && !bus.o_ready)) begin
            n_err++;
            $display("FAIL i_ready: got %b, required %b", bus.i_ready, !(bus.o_valid && !bus.o_ready));
         end
         if (was_stall) begin
            n_chk++;
            if ({bus.o_valid, bus.o_last, bus.bid, bus.fea_a, bus.fea_b, bus.fea_c, bus.fea_d} !== held) begin
               n_err++;
               $display("FAIL hold: outputs %h, required %h", {bus.o_valid, bus.o_last, bus.bid, bus.fea_a, bus.fea_b, bus.fea_c, bus.fea_d}, held);
            end
         end
         if (bus.o_valid && bus.o_ready) begin
            n_chk++;
            if (q.size() == 0) begin
               n_err++;
               $display("FAIL extra_block: got bid %0d, required none", bus.bid);
            end else begin
               exp_t e;
               e = q.pop_front();
               if (bus.bid !== ID_W'(e.bid) || bus.fea_a !== e.a || bus.fea_b !== e.b ||
                   bus.fea_c !== e.c || bus.fea_d !== e.d || bus.o_last !== e.last) begin
                  n_err++;
                  $display("FAIL block: got bid=%0d a=%h b=%h c=%h d=%h last=%b, required bid=%0d a=%h b=%h c=%h d=%h last=%b",
                           bus.bid, bus.fea_a, bus.fea_b, bus.fea_c, bus.fea_d, bus.o_last,
                           e.bid, e.a, e.b, e.c, e.d, e.last);
               end
               if (e.lat && !was_stall) begin
                  n_chk++;
                  if (cyc != e.acc + 1) begin
                     n_err++;
                     $display("FAIL latency: bid %0d loaded %0d cycles after accept, required 1", e.bid, cyc - e.acc);
                  end
               end
            end
         end
         was_stall = bus.o_valid && !bus.o_ready;
         held = {bus.o_valid, bus.o_last, bus.bid, bus.fea_a, bus.fea_b, bus.fea_c, bus.fea_d};
      end else begin
         was_stall = 0;
      end
   end

   initial begin
      bus.bin = '0;
      bus.i_valid = 1'b0;
      bus.i_sof = 1'b0;
      mx = 0;
      my = 0;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_chk++;
      if (bus.o_valid !== 1'b0 || bus.o_last !== 1'b0 || bus.i_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_ctrl: o_valid=%b o_last=%b i_ready=%b, required 0 0 1", bus.o_valid, bus.o_last, bus.i_ready);
      end
      n_chk++;
      if (bus.bid !== '0 || {bus.fea_a, bus.fea_b, bus.fea_c, bus.fea_d} !== '0) begin
         n_err++;
         $display("FAIL reset_data: bid=%0d fea=%h, required 0", bus.bid, {bus.fea_a, bus.fea_b, bus.fea_c, bus.fea_d});
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      idle(2);

      // full frame, back-to-back, latency tracked
      lat_mode = 1;
      cells(0, 12, 1);
      lat_mode = 0;
      drain();

      // backpressure on bid 2
      mode = 2;
      bp_done = 0;
      cells(0, 12, 1);
      drain();
      n_chk++;
      if (!bp_done) begin
        n_err++;
        $display("FAIL backpressure: bid 2 hold seen=%b, required 1", bp_done);
      end
      mode = 0;

      // two frames without a second sof
      lat_mode = 1;
      cells(0, 24, 1);
      lat_mode = 0;
      drain();

      // sof in the middle of a frame
      cells(0, 6, 1);
      cells(50, 12, 1);
      drain();

      // reset after cell 7, then a frame without sof
      cells(0, 8, 1);
      @(negedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      q.delete();
      mx = 0;
      my = 0;
      @(negedge clk);
      n_chk++;
      if (bus.o_valid !== 1'b0) begin
         n_err++;
         $display("FAIL mid_reset: o_valid=%b, required 0", bus.o_valid);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      cells(100, 12, 0);
      drain();

      // random gaps, random data, random downstream ready
      mode = 1;
      for (int f = 0; f < 4; f++) begin
         for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
            send(CW'($urandom), i == 0);
         end
      end
      drain();
      mode = 0;
      idle(4);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
